// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and the
// multi-cycle nop rule shared by alu_mc.
package alu_pkg;

  localparam logic [3:0] OP_ADDU = 4'b0000;
  localparam logic [3:0] OP_SUBU = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SLL  = 4'b1110;

  localparam logic [4:0] OP_MULTU = 5'b10000;
  localparam logic [4:0] OP_MULT  = 5'b10001;
  localparam logic [4:0] OP_DIVU  = 5'b10010;
  localparam logic [4:0] OP_DIV   = 5'b10011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Unassigned multi-cycle codes complete at once and touch nothing.
  function automatic logic is_nop(input logic [4:0] op);
    return op[4] && (op[3:2] != 2'b00);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational single-cycle ALU
// producing a result and zero/carry/negative/overflow.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SHW-1:0]   sh;
  logic             ov_add;
  logic             ov_sub;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    sh  = a[SHW-1:0];
    ov_add = (a[WIDTH-1] == b[WIDTH-1])
          && (sum[WIDTH-1] != a[WIDTH-1]);
    ov_sub = (a[WIDTH-1] != b[WIDTH-1])
          && (dif[WIDTH-1] != a[WIDTH-1]);
    res      = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    // Signed and unsigned add/sub differ only in trapping, not here.
    unique casez (op)
      4'b00?0: begin
        res      = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = ov_add;
      end
      4'b00?1: begin
        res      = dif[WIDTH-1:0];
        carry    = dif[WIDTH];
        overflow = ov_sub;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      4'b100?: res = b << (WIDTH / 2);
      OP_SLT:
        res = {{(WIDTH-1){1'b0}},
               ($signed(a) < $signed(b))};
      OP_SLTU:
        res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA:  res = $signed(b) >>> sh;
      OP_SRL:  res = b >> sh;
      4'b111?: res = b << sh;
      default: res = '0;
    endcase
    zero     = (res == '0);
    negative = res[WIDTH-1];
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered single-cycle ALU plus an
// iterative multiply/divide unit writing hi/lo.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lq_q, lq_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             div_q, div_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [3:0]       flg_q, flg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] c_res;
  logic             c_z, c_c, c_n, c_v;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (op[3:0]),
    .a        (a),
    .b        (b),
    .res      (c_res),
    .zero     (c_z),
    .carry    (c_c),
    .negative (c_n),
    .overflow (c_v)
  );

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               flip;

  always_comb begin
    mul_sum = {1'b0, acc_q}
            + (lq_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    div_sh  = {acc_q, lq_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, m_q});
    flip    = sgn_q && (neg_a_q ^ neg_b_q);
    prod    = {acc_q, lq_q};
    if (flip) prod = -prod;
    quo = flip ? -lq_q : lq_q;
    rem = (sgn_q && neg_a_q) ? -acc_q : acc_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lq_d    = lq_q;
    m_d     = m_q;
    a_d     = a_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    r_d     = r_q;
    flg_d   = flg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[4]) begin
            r_d    = c_res;
            flg_d  = {c_z, c_c, c_n, c_v};
            done_d = 1'b1;
          end else if (is_nop(op)) begin
            done_d = 1'b1;
          end else begin
            sgn_d   = op[0];
            div_d   = op[1];
            neg_a_d = op[0] & a[WIDTH-1];
            neg_b_d = op[0] & b[WIDTH-1];
            lq_d    = neg_a_d ? -a : a;
            m_d     = neg_b_d ? -b : b;
            a_d     = a;
            acc_d   = '0;
            cnt_d   = CNT_LAST;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        // Divide: restoring step; multiply: shift-add step.
        if (div_q) begin
          acc_d = div_ge ? (div_sh[WIDTH-1:0] - m_q)
                         : div_sh[WIDTH-1:0];
          lq_d  = {lq_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          lq_d  = {mul_sum[0], lq_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!div_q) begin
          {hi_d, lo_d} = prod;
          dz_d = 1'b0;
        end else if (m_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quo;
          dz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lq_q    <= '0;
      m_q     <= '0;
      a_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      r_q     <= '0;
      flg_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lq_q    <= lq_d;
      m_q     <= m_d;
      a_q     <= a_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      r_q     <= r_d;
      flg_q   <= flg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign r        = r_q;
  assign zero     = flg_q[3];
  assign carry    = flg_q[2];
  assign negative = flg_q[1];
  assign overflow = flg_q[0];
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scoreboard bench for alu_mc
// covering single ops, mul/div, busy and reset abort.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int NS = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] r, hi, lo;
  logic         zero, carry, negative, overflow;
  logic         div_zero, busy, done;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_r = '0;

  typedef struct {
    logic         multi;
    logic [W-1:0] r;
    logic [3:0]   flg;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];

  logic [4:0] s_op [NS] = '{
    5'b00010, 5'b00001, 5'b01010, 5'b01011,
    5'b01100, 5'b01000, 5'b00000, 5'b00011,
    5'b00100, 5'b00101, 5'b00110, 5'b00111,
    5'b01101, 5'b01110, 5'b01111, 5'b01001};
  logic [W-1:0] s_a [NS] = '{
    32'h7FFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF,
    32'h00000004, 32'h00000000, 32'hFFFFFFFF, 32'h80000000,
    32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h00000000,
    32'd31,       32'd31,       32'h00000024, 32'h00000000};
  logic [W-1:0] s_b [NS] = '{
    32'h00000001, 32'h00000005, 32'h00000001, 32'h00000001,
    32'h80000000, 32'h00001234, 32'h00000001, 32'h00000001,
    32'hFF00FF00, 32'h0F0F0F0F, 32'hFF00FF00, 32'h00000000,
    32'h80000000, 32'h00000001, 32'h0000000F, 32'hFFFFABCD};
  logic [W-1:0] s_r [NS] = '{
    32'h80000000, 32'hFFFFFFFE, 32'h00000001, 32'h00000000,
    32'hF8000000, 32'h12340000, 32'h00000000, 32'h7FFFFFFF,
    32'hF000F000, 32'hFFFFFFFF, 32'h00FFFF00, 32'hFFFFFFFF,
    32'h00000001, 32'h80000000, 32'h000000F0, 32'hABCD0000};
  // {zero, carry, negative, overflow}
  logic [3:0] s_f [NS] = '{
    4'b0011, 4'b0110, 4'b0000, 4'b1000,
    4'b0010, 4'b0000, 4'b1100, 4'b0001,
    4'b0010, 4'b0010, 4'b0000, 4'b0010,
    4'b0000, 4'b0010, 4'b0000, 4'b0010};

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .r        (r),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    chk("sb_size", 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (e.multi) begin
      chk("hi", hi, e.hi);
      chk("lo", lo, e.lo);
      chk("div_zero", div_zero, e.dz);
    end else begin
      chk("r", r, e.r);
      chk("flags", {zero, carry, negative, overflow}, e.flg);
    end
  endtask

  task automatic run_multi(input logic [4:0] o,
                           input logic [W-1:0] x,
                           input logic [W-1:0] y,
                           input logic [W-1:0] ehi,
                           input logic [W-1:0] elo,
                           input logic edz,
                           input int elat,
                           input bit poke);
    int n;
    int nb;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back('{multi: 1'b1, r: '0, flg: '0,
                   hi: ehi, lo: elo, dz: edz});
    @(posedge clk);
    n = 0;
    nb = 0;
    while (n < 100) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && (n == 5 || n == 20)) begin
        op = OP_MULTU; a = '1; b = '1; start = 1'b1;
      end
      if (done) break;
      if (busy) nb++;
      @(posedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
    chk("latency", n, elat);
    chk("busy_cycles", nb, elat);
    chk("busy_at_done", busy, 1'b0);
    chk("r_held", r, exp_r);
    check_out();
  endtask

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_r", r, 0);
    chk("rst_flags", {zero, carry, negative, overflow}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Back-to-back single-cycle ops, one result per cycle.
    for (int i = 0; i <= NS; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("done_single", done, 1'b1);
        check_out();
      end
      if (i < NS) begin
        op = s_op[i]; a = s_a[i]; b = s_b[i]; start = 1'b1;
        exp_r = s_r[i];
        sb.push_back('{multi: 1'b0, r: s_r[i], flg: s_f[i],
                       hi: '0, lo: '0, dz: 1'b0});
      end else begin
        start = 1'b0;
      end
    end
    chk("hi_held", hi, 0);
    chk("lo_held", lo, 0);
    @(negedge clk);
    chk("done_idle", done, 0);

    run_multi(OP_MULT, 32'hFFFFFFFF, 32'd5,
              32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 33, 1'b0);
    run_multi(OP_MULTU, 32'hFFFFFFFF, 32'd5,
              32'h00000004, 32'hFFFFFFFB, 1'b0, 33, 1'b0);
    run_multi(OP_DIV, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    run_multi(OP_DIVU, 32'h80000000, 32'd0,
              32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 1'b0);
    run_multi(5'b10100, 32'd1, 32'd1,
              32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
    run_multi(OP_DIVU, 32'd9, 32'd3,
              32'h00000000, 32'h00000003, 1'b0, 33, 1'b0);
    run_multi(OP_DIV, 32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000, 1'b0, 33, 1'b0);
    run_multi(OP_DIV, 32'd7, 32'hFFFFFFFE,
              32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    run_multi(OP_MULT, 32'h12345678, 32'h00000010,
              32'h00000001, 32'h23456780, 1'b0, 33, 1'b1);

    // Single op issued on the done cycle.
    op = 5'b00010; a = 32'd2; b = 32'd3; start = 1'b1;
    exp_r = 32'd5;
    sb.push_back('{multi: 1'b0, r: 32'd5, flg: 4'b0000,
                   hi: '0, lo: '0, dz: 1'b0});
    @(negedge clk);
    start = 1'b0;
    chk("done_after_done", done, 1'b1);
    check_out();
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("extra_done", nd, 0);
    chk("hi_after_poke", hi, 32'h00000001);
    chk("lo_after_poke", lo, 32'h23456780);

    // Reset mid-divide aborts with no done.
    @(negedge clk);
    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_before_abort", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("done_after_abort", nd, 0);
    chk("post_r", r, 0);
    chk("post_flags", {zero, carry, negative, overflow}, 0);
    chk("post_hi", hi, 0);
    chk("post_lo", lo, 0);
    chk("post_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
